dma_pattern_writer: RTL and testbench

//  Write-side stimulus generator for the DMA/AHB-Lite path; the source end of the read/serialize/verify loop.
//  On Write_Request it generates a pseudo-random byte stream from an 8-bit LFSR and packs 4 bytes per word.

---
 rtl/dma_gen_pkg.sv | 27 ++
 rtl/pattern_lfsr8.sv | 34 +++
 rtl/dma_pattern_writer.sv | 153 +++++++++++++++
 tb/tb_dma_pattern_writer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_gen_pkg.sv
// -----------------------------------------------------------------------------
// dma_gen_pkg
// Shared definitions for the DMA pattern writer and its matching verifier:
//   - Writer_state       : writer FSM state encoding
//   - LFSR_ZERO_SEED_SUB : value used in place of an all-zero seed (an all-zero
//                          LFSR state would lock up)
//   - LFSR_RESET_VALUE   : LFSR register value out of reset
//   - lfsr8_next()       : one step of the 8-bit pattern LFSR
// -----------------------------------------------------------------------------
package dma_gen_pkg;

  typedef enum logic [1:0] {
    Writer_IDLE,
    Writer_PACK,
    Writer_WRITE,
    Writer_DONE
  } Writer_state;

  localparam logic [7:0] LFSR_ZERO_SEED_SUB = 8'h01;
  localparam logic [7:0] LFSR_RESET_VALUE   = 8'h01;

  // Shift left, feed back the XOR of taps 7, 5, 4 and 3 into bit 0.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/pattern_lfsr8.sv
// -----------------------------------------------------------------------------
// pattern_lfsr8
// 8-bit pattern LFSR. The register itself is the current pattern byte, so
// after a load the first byte presented is the seed. The verifier instantiates
// the same block to regenerate the expected stream.
// Ports:
//   CLK, RESETn  clock, synchronous active-low reset
//   load         load seed (a zero seed becomes LFSR_ZERO_SEED_SUB); wins over step
//   seed         seed value
//   step         advance one LFSR step
//   value        current pattern byte
// -----------------------------------------------------------------------------
module pattern_lfsr8
  import dma_gen_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      value <= LFSR_RESET_VALUE;
    end else if (load) begin
      value <= (seed == 8'h00) ? LFSR_ZERO_SEED_SUB : seed;
    end else if (step) begin
      value <= lfsr8_next(value);
    end
  end

endmodule

// File: rtl/dma_pattern_writer.sv
// -----------------------------------------------------------------------------
// dma_pattern_writer
// Source end of the DMA read/serialize/verify loop. On Write_Request it packs
// LFSR bytes four to a word (lane 0 = bits [7:0]) and issues each word as a
// DMA write at consecutive word addresses from the latched base.
// Parameters:
//   WORD_CNT_W   width of i_word_count and the remaining-word counter
//   ACK_TIMEOUT  cycles DMA_WRITE may stay high without ack before abort (>=1)
// Ports:
//   CLK, RESETn          clock, synchronous active-low reset
//   i_RCC_DMA_ADDR_HIGH  base address [31:16]
//   i_RCC_DMA_ADDR_LOW   base address [15:0]; bits [1:0] ignored
//   i_word_count         words to write, sampled with Write_Request
//   i_seed               LFSR seed, sampled with Write_Request
//   Write_Request        start pulse, honoured only when idle
//   DMA_WRITE            write request, held until acked or timed out
//   DMA_WRITE_addr       word address, stable while DMA_WRITE=1
//   DMA_WRITE_data       packed word, stable while DMA_WRITE=1
//   i_DMA_WRITE_ack      write accepted, only looked at while DMA_WRITE=1
//   o_busy               high whenever the FSM is not idle
//   o_done               one-cycle pulse at the end of every run
//   o_error              sticky ack-timeout flag, cleared by the next start
// All outputs are registered.
// -----------------------------------------------------------------------------
module dma_pattern_writer
  import dma_gen_pkg::*;
#(
  parameter int WORD_CNT_W  = 16,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [15:0]           i_RCC_DMA_ADDR_HIGH,
  input  logic [15:0]           i_RCC_DMA_ADDR_LOW,
  input  logic [WORD_CNT_W-1:0] i_word_count,
  input  logic [7:0]            i_seed,
  input  logic                  Write_Request,
  output logic                  DMA_WRITE,
  output logic [31:0]           DMA_WRITE_addr,
  output logic [31:0]           DMA_WRITE_data,
  input  logic                  i_DMA_WRITE_ack,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int              TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  Writer_state           state;
  logic [WORD_CNT_W-1:0] remaining;
  logic [1:0]            lane;
  logic [TO_W-1:0]       ack_wait;
  logic [7:0]            lfsr_byte;
  logic                  lfsr_load;
  logic                  lfsr_step;
  logic                  unused_addr_bits;

  // Word alignment is forced, so the two low address bits are never used.
  assign unused_addr_bits = ^i_RCC_DMA_ADDR_LOW[1:0];

  // The LFSR is (re)seeded on the accepting edge, so its first PACK cycle
  // already presents the seed; it then advances once per packed byte and
  // holds across WRITE so the stream continues seamlessly into the next word.
  assign lfsr_load = (state == Writer_IDLE) && Write_Request;
  assign lfsr_step = (state == Writer_PACK);

  pattern_lfsr8 u_lfsr (
    .CLK    (CLK),
    .RESETn (RESETn),
    .load   (lfsr_load),
    .seed   (i_seed),
    .step   (lfsr_step),
    .value  (lfsr_byte)
  );

  // NOTE: every register here uses non-blocking assignment, so all decisions
  // within one edge see the pre-edge values of state, counters and outputs.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state          <= Writer_IDLE;
      remaining      <= '0;
      lane           <= '0;
      ack_wait       <= '0;
      DMA_WRITE      <= 1'b0;
      DMA_WRITE_addr <= '0;
      DMA_WRITE_data <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      o_done <= 1'b0;

      case (state)
        Writer_IDLE: begin
          if (Write_Request) begin
            DMA_WRITE_addr <= {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW[15:2], 2'b00};
            remaining      <= i_word_count;
            lane           <= '0;
            o_error        <= 1'b0;
            o_busy         <= 1'b1;
            state          <= (i_word_count == '0) ? Writer_DONE : Writer_PACK;
          end
        end

        // Bytes go straight into the output data register: DMA_WRITE is low
        // throughout PACK, so the partially built word is never presented.
        Writer_PACK: begin
          DMA_WRITE_data[{lane, 3'b000} +: 8] <= lfsr_byte;
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            state <= Writer_WRITE;
          end
        end

        // First WRITE cycle raises DMA_WRITE; from then on each cycle either
        // sees the ack, hits the timeout, or counts one more waiting cycle.
        Writer_WRITE: begin
          if (!DMA_WRITE) begin
            DMA_WRITE <= 1'b1;
            ack_wait  <= '0;
          end else if (i_DMA_WRITE_ack) begin
            DMA_WRITE <= 1'b0;
            remaining <= remaining - 1'b1;
            if (remaining == WORD_CNT_W'(1)) begin
              state <= Writer_DONE;
            end else begin
              DMA_WRITE_addr <= DMA_WRITE_addr + 32'd4;
              state          <= Writer_PACK;
            end
          end else if (ack_wait == TO_LAST) begin
            DMA_WRITE <= 1'b0;
            o_error   <= 1'b1;
            state     <= Writer_DONE;
          end else begin
            ack_wait <= ack_wait + 1'b1;
          end
        end

        Writer_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= Writer_IDLE;
        end

        default: begin
          state <= Writer_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_pattern_writer.sv
// -----------------------------------------------------------------------------
// tb_dma_pattern_writer
// Self-checking bench for dma_pattern_writer. Expected words are built from
// the byte-stream definition (seeded LFSR, four bytes per word, lane 0 first);
// expected timing comes from closed-form cycle arithmetic per run.
// -----------------------------------------------------------------------------
module tb_dma_pattern_writer;

  localparam int ACK_TO = 8;
  localparam int LIMIT  = 300;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] addr_high;
  logic [15:0] addr_low;
  logic [15:0] word_count;
  logic [7:0]  seed_in;
  logic        write_request;
  logic        dma_write;
  logic [31:0] dma_addr;
  logic [31:0] dma_data;
  logic        dma_ack;
  logic        busy;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dma_pattern_writer #(
    .WORD_CNT_W  (16),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .CLK                 (clk),
    .RESETn              (resetn),
    .i_RCC_DMA_ADDR_HIGH (addr_high),
    .i_RCC_DMA_ADDR_LOW  (addr_low),
    .i_word_count        (word_count),
    .i_seed              (seed_in),
    .Write_Request       (write_request),
    .DMA_WRITE           (dma_write),
    .DMA_WRITE_addr      (dma_addr),
    .DMA_WRITE_data      (dma_data),
    .i_DMA_WRITE_ack     (dma_ack),
    .o_busy              (busy),
    .o_done              (done),
    .o_error             (error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference LFSR step: feedback is the parity of the tap mask 0xB8.
  function automatic logic [7:0] ref_step(input logic [7:0] b);
    return {b[6:0], ^(b & 8'hB8)};
  endfunction

  // Runs one job. Expected (addr, data) per word comes from the byte-stream
  // model; expected timing: first DMA_WRITE 5 cycles after the sampling edge,
  // next DMA_WRITE 5 cycles after each ack edge, o_done 1 cycle after the
  // final ack (or after the timeout drop). Cycle 0 = right after the edge
  // that samples Write_Request.
  task automatic run_job(input logic [7:0] seed, input int count, input logic [31:0] base,
                         input int ack_delay, input bit no_ack, input bit req_midrun,
                         output logic [31:0] first_addr, output logic [31:0] first_data,
                         output logic [31:0] last_addr, output logic [31:0] last_data,
                         output int acked, output logic err_end);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] word;
    logic [31:0] held_a;
    logic [31:0] held_d;
    logic [7:0]  b;
    int cyc, rise_ref, hold, attempts, done_cyc, done_pulses, busy_cycles;
    int exp_done, exp_attempts;
    bit stable, finished;

    b = (seed == 8'h00) ? 8'h01 : seed;
    for (int w = 0; w < count; w++) begin
      word = '0;
      for (int l = 0; l < 4; l++) begin
        word[8*l +: 8] = b;
        b = ref_step(b);
      end
      ea.push_back((base & 32'hFFFF_FFFC) + 32'(4 * w));
      ed.push_back(word);
    end
    exp_done     = no_ack ? (5 + ACK_TO + 1) : (count * (ack_delay + 6) + 1);
    exp_attempts = no_ack ? ((count > 0) ? 1 : 0) : count;

    first_addr = '0; first_data = '0; last_addr = '0; last_data = '0;
    acked = 0; err_end = 1'b0;
    held_a = '0; held_d = '0;
    rise_ref = 0; hold = 0; attempts = 0; done_cyc = -1; done_pulses = 0;
    stable = 1'b1; finished = 1'b0;

    @(negedge clk);
    addr_high     = base[31:16];
    addr_low      = base[15:0];
    word_count    = 16'(count);
    seed_in       = seed;
    write_request = 1'b1;
    @(negedge clk);
    write_request = 1'b0;
    cyc = 0;
    check("error_cleared_on_start", error, 1'b0);
    busy_cycles = busy ? 1 : 0;

    while (!finished) begin
      @(negedge clk);
      cyc++;
      dma_ack = 1'b0;
      if (req_midrun && cyc == 7) begin
        addr_high = 16'h5555; addr_low = 16'h0000; word_count = 16'd5; seed_in = 8'h77;
        write_request = 1'b1;
      end
      if (req_midrun && cyc == 8) write_request = 1'b0;
      if (busy) busy_cycles++;

      if (dma_write) begin
        if (hold == 0) begin
          attempts++;
          check("write_rise_latency", cyc - rise_ref, 5);
          if (attempts <= ea.size()) begin
            check("write_addr", dma_addr, ea[attempts-1]);
            check("write_data", dma_data, ed[attempts-1]);
          end else begin
            check("extra_write", attempts, ea.size());
          end
          held_a = dma_addr; held_d = dma_data; stable = 1'b1;
          if (attempts == 1) begin first_addr = dma_addr; first_data = dma_data; end
          last_addr = dma_addr; last_data = dma_data;
        end else if (dma_addr !== held_a || dma_data !== held_d) begin
          stable = 1'b0;
        end
        hold++;
        if (!no_ack && hold == ack_delay + 1) begin
          dma_ack = 1'b1;
          check("write_stable_until_ack", stable, 1'b1);
          acked++;
          rise_ref = cyc + 1;
          hold = 0;
        end
      end else if (hold > 0) begin
        check("timeout_high_cycles", hold, ACK_TO);
        check("write_stable_until_timeout", stable, 1'b1);
        hold = 0;
      end

      if (done) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check("busy_low_at_done", busy, 1'b0);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1'b1;
      if (cyc >= LIMIT) finished = 1'b1;
    end
    dma_ack = 1'b0;
    err_end = error;

    check("done_cycle", done_cyc, exp_done);
    check("done_pulses", done_pulses, 1);
    check("busy_cycles", busy_cycles, exp_done);
    check("write_attempts", attempts, exp_attempts);
  endtask

  typedef struct {
    logic [7:0]  seed;
    int          count;
    logic [31:0] base;
    int          ack_delay;
    bit          no_ack;
    bit          req_midrun;
    logic [31:0] exp_first_addr;
    logic [31:0] exp_first_data;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_last_data;
    int          exp_acked;
    logic        exp_error;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] fa, fd, la, ld;
    int          ack_cnt;
    logic        err;
    int          seen, guard, stray_done, stray_write;

    vecs[0] = '{8'h01, 2, 32'h0000_1000, 0, 1'b0, 1'b0,
                32'h0000_1000, 32'h0804_0201, 32'h0000_1004, 32'h8E47_2311, 2, 1'b0};
    vecs[1] = '{8'h5A, 0, 32'h0000_2000, 0, 1'b0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0};
    vecs[2] = '{8'h00, 2, 32'h0000_1000, 3, 1'b0, 1'b0,
                32'h0000_1000, 32'h0804_0201, 32'h0000_1004, 32'h8E47_2311, 2, 1'b0};
    vecs[3] = '{8'h01, 3, 32'h0000_3000, 0, 1'b1, 1'b0,
                32'h0000_3000, 32'h0804_0201, 32'h0000_3000, 32'h0804_0201, 0, 1'b1};
    vecs[4] = '{8'h01, 2, 32'hFFFF_FFFE, 0, 1'b0, 1'b1,
                32'hFFFF_FFFC, 32'h0804_0201, 32'h0000_0000, 32'h8E47_2311, 2, 1'b0};

    resetn = 1'b0; addr_high = '0; addr_low = '0; word_count = '0; seed_in = '0;
    write_request = 1'b0; dma_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dma_write", dma_write, 1'b0);
    check("reset_addr", dma_addr, 32'h0);
    check("reset_data", dma_data, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_error", error, 1'b0);
    resetn = 1'b1;

    // Table-driven scenarios.
    foreach (vecs[i]) begin
      run_job(vecs[i].seed, vecs[i].count, vecs[i].base, vecs[i].ack_delay,
              vecs[i].no_ack, vecs[i].req_midrun, fa, fd, la, ld, ack_cnt, err);
      if (vecs[i].count != 0) begin
        check($sformatf("vec%0d_first_addr", i), fa, vecs[i].exp_first_addr);
        check($sformatf("vec%0d_first_data", i), fd, vecs[i].exp_first_data);
        check($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last_addr);
        check($sformatf("vec%0d_last_data", i), ld, vecs[i].exp_last_data);
      end
      check($sformatf("vec%0d_acked", i), ack_cnt, vecs[i].exp_acked);
      check($sformatf("vec%0d_error", i), err, vecs[i].exp_error);
    end

    // Reset during the second WRITE of a run.
    @(negedge clk);
    addr_high = 16'h0000; addr_low = 16'h4000; word_count = 16'd3; seed_in = 8'h3C;
    write_request = 1'b1;
    @(negedge clk);
    write_request = 1'b0;
    seen = 0; guard = 0;
    while (seen < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      dma_ack = 1'b0;
      if (dma_write) begin
        seen++;
        if (seen == 1) dma_ack = 1'b1;
      end
    end
    check("reset_reached_2nd_write", seen, 2);
    resetn = 1'b0;
    dma_ack = 1'b0;
    @(negedge clk);
    check("midrun_reset_dma_write", dma_write, 1'b0);
    check("midrun_reset_addr", dma_addr, 32'h0);
    check("midrun_reset_data", dma_data, 32'h0);
    check("midrun_reset_busy", busy, 1'b0);
    check("midrun_reset_done", done, 1'b0);
    check("midrun_reset_error", error, 1'b0);
    resetn = 1'b1;
    stray_done = 0; stray_write = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) stray_done++;
      if (dma_write) stray_write++;
    end
    check("no_done_after_reset", stray_done, 0);
    check("no_write_after_reset", stray_write, 0);
    run_job(8'hA5, 2, 32'h0000_8000, 1, 1'b0, 1'b0, fa, fd, la, ld, ack_cnt, err);
    check("restart_first_addr", fa, 32'h0000_8000);
    check("restart_last_addr", la, 32'h0000_8004);
    check("restart_acked", ack_cnt, 2);

    // Randomised runs against the byte-stream model.
    for (int r = 0; r < 8; r++) begin
      logic [7:0]  rs;
      logic [31:0] rb;
      int          rc, rd;
      bit          rm;
      rs = 8'($urandom);
      rb = $urandom;
      rc = $urandom_range(1, 4);
      rd = $urandom_range(0, 4);
      rm = (rc >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_job(rs, rc, rb, rd, 1'b0, rm, fa, fd, la, ld, ack_cnt, err);
      check($sformatf("rand%0d_acked", r), ack_cnt, rc);
      check($sformatf("rand%0d_error", r), err, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
